// File: rtl/id_operand_resolver_pkg.sv
// Shared pipeline definitions for the ID-stage operand resolver:
// FSM state encoding, operand-source tags, opcode constants and a
// saturating counter helper used by the optional statistics block.
package id_operand_resolver_pkg;

   // Resolver control states
   typedef enum logic [1:0] {
      ST_RUN       = 2'd0,
      ST_LOAD_WAIT = 2'd1,
      ST_HOLD      = 2'd2
   } fsm_state_t;

   // Where a resolved operand came from
   typedef enum logic [2:0] {
      SRC_RF   = 3'd0,
      SRC_WB   = 3'd1,
      SRC_MEM  = 3'd2,
      SRC_EX   = 3'd3,
      SRC_ZERO = 3'd4
   } operand_src_t;

   // Base opcodes of the pipeline's instruction classes
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;

   localparam int unsigned STAT_W = 32;

   // Add a small increment to a counter, sticking at all-ones
   function automatic logic [STAT_W-1:0] sat_add(input logic [STAT_W-1:0] cnt,
                                                 input logic [1:0]        inc);
      logic [STAT_W:0] sum;
      sum = {1'b0, cnt} + {{(STAT_W-1){1'b0}}, inc};
      return sum[STAT_W] ? {STAT_W{1'b1}} : sum[STAT_W-1:0];
   endfunction

endpackage

// File: rtl/id_operand_resolver_if.sv
// Bus between the ID stage control and the operand resolver.
// Optional statistics outputs appear when FWD_STATS_EN is defined.
//
// Handshake: there is no valid/ready pair on this bus. id_valid qualifies
// the decoding instruction; id_stall is the resolver's back-pressure and,
// when high, the instruction must stay in ID; the operands are consumed by
// ID/EX in a cycle where id_valid=1, id_stall=0 and flush=0.
interface id_operand_resolver_if #(
   parameter int XLEN   = 32,
   parameter int REG_AW = 5
);
   logic              flush;
   logic              stall_in;
   logic              id_valid;
   logic [REG_AW-1:0] rs1;
   logic [REG_AW-1:0] rs2;
   logic              use_rs1;
   logic              use_rs2;
   logic [XLEN-1:0]   rf_rdata1;
   logic [XLEN-1:0]   rf_rdata2;
   logic              ex_valid;
   logic              ex_wr_en;
   logic              ex_is_load;
   logic [REG_AW-1:0] ex_rd;
   logic [XLEN-1:0]   ex_fwd_data;
   logic              mem_valid;
   logic              mem_wr_en;
   logic              mem_wait;
   logic [REG_AW-1:0] mem_rd;
   logic [XLEN-1:0]   mem_fwd_data;
   logic              wb_valid;
   logic              wb_wr_en;
   logic [REG_AW-1:0] wb_rd;
   logic [XLEN-1:0]   wb_data;
   logic [XLEN-1:0]   op1;
   logic [XLEN-1:0]   op2;
   logic              id_stall;
   logic              ex_bubble;
`ifdef FWD_STATS_EN
   logic [31:0]       stat_load_use;
   logic [31:0]       stat_wait_cycles;
   logic [31:0]       stat_fwd_ex;
   logic [31:0]       stat_fwd_mem;
`endif

   modport master (
      output flush, stall_in, id_valid, rs1, rs2, use_rs1, use_rs2,
             rf_rdata1, rf_rdata2,
             ex_valid, ex_wr_en, ex_is_load, ex_rd, ex_fwd_data,
             mem_valid, mem_wr_en, mem_wait, mem_rd, mem_fwd_data,
             wb_valid, wb_wr_en, wb_rd, wb_data,
      input  op1, op2, id_stall, ex_bubble
`ifdef FWD_STATS_EN
      , input stat_load_use, stat_wait_cycles, stat_fwd_ex, stat_fwd_mem
`endif
   );

   modport slave (
      input  flush, stall_in, id_valid, rs1, rs2, use_rs1, use_rs2,
             rf_rdata1, rf_rdata2,
             ex_valid, ex_wr_en, ex_is_load, ex_rd, ex_fwd_data,
             mem_valid, mem_wr_en, mem_wait, mem_rd, mem_fwd_data,
             wb_valid, wb_wr_en, wb_rd, wb_data,
      output op1, op2, id_stall, ex_bubble
`ifdef FWD_STATS_EN
      , output stat_load_use, stat_wait_cycles, stat_fwd_ex, stat_fwd_mem
`endif
   );

endinterface

// File: rtl/id_operand_resolver_fwd_src_select.sv
// Per-operand forwarding mux: matches one source index against the EX,
// MEM and WB producers and picks the highest-priority hit, falling back
// to register-file data. Register x0 always reads as zero.
module fwd_src_select
   import id_operand_resolver_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int REG_AW = 5
) (
   input  logic [REG_AW-1:0] rs,
   input  logic              use_rs,
   input  logic [XLEN-1:0]   rf_rdata,
   input  logic              ex_valid,
   input  logic              ex_wr_en,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic [XLEN-1:0]   ex_fwd_data,
   input  logic              mem_valid,
   input  logic              mem_wr_en,
   input  logic [REG_AW-1:0] mem_rd,
   input  logic [XLEN-1:0]   mem_fwd_data,
   input  logic              wb_valid,
   input  logic              wb_wr_en,
   input  logic [REG_AW-1:0] wb_rd,
   input  logic [XLEN-1:0]   wb_data,
   output logic [XLEN-1:0]   data,
   output operand_src_t      src,
   output logic              ex_hit
);

   logic rs_nz;
   logic mem_hit;
   logic wb_hit;

   // Producer match and EX > MEM > WB > RF priority select
   always_comb begin
      rs_nz   = (rs != '0);
      ex_hit  = ex_valid  & ex_wr_en  & (ex_rd  == rs) & rs_nz & use_rs;
      mem_hit = mem_valid & mem_wr_en & (mem_rd == rs) & rs_nz & use_rs;
      wb_hit  = wb_valid  & wb_wr_en  & (wb_rd  == rs) & rs_nz & use_rs;
      data    = rf_rdata;
      src     = SRC_RF;
      if (!rs_nz) begin
         data = '0;
         src  = SRC_ZERO;
      end else if (ex_hit) begin
         data = ex_fwd_data;
         src  = SRC_EX;
      end else if (mem_hit) begin
         data = mem_fwd_data;
         src  = SRC_MEM;
      end else if (wb_hit) begin
         data = wb_data;
         src  = SRC_WB;
      end
   end

endmodule

// File: rtl/id_operand_resolver.sv
// ID-stage operand resolver. Resolves rs1/rs2 through the forwarding
// network, inserts load-use bubbles, waits out data-memory latency and
// holds operands across external freezes so ID/EX always latches correct
// values. Defining FWD_STATS_EN adds saturating event counters.
module id_operand_resolver
   import id_operand_resolver_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int REG_AW = 5
) (
   input  logic                 clk,
   input  logic                 rst_n,
   id_operand_resolver_if.slave bus,
   output fsm_state_t           state_dbg
);

   fsm_state_t      state_q, state_d;
   logic [XLEN-1:0] hold1_q, hold1_d;
   logic [XLEN-1:0] hold2_q, hold2_d;

   logic [XLEN-1:0] res1, res2;
   operand_src_t    src1, src2;
   logic            ex_hit1, ex_hit2;
   logic            load_use;

   logic [XLEN-1:0] op1, op2;
   logic            id_stall;
   logic            ex_bubble;

   fwd_src_select #(.XLEN(XLEN), .REG_AW(REG_AW)) u_sel_rs1 (
      .rs           (bus.rs1),
      .use_rs       (bus.use_rs1),
      .rf_rdata     (bus.rf_rdata1),
      .ex_valid     (bus.ex_valid),
      .ex_wr_en     (bus.ex_wr_en),
      .ex_rd        (bus.ex_rd),
      .ex_fwd_data  (bus.ex_fwd_data),
      .mem_valid    (bus.mem_valid),
      .mem_wr_en    (bus.mem_wr_en),
      .mem_rd       (bus.mem_rd),
      .mem_fwd_data (bus.mem_fwd_data),
      .wb_valid     (bus.wb_valid),
      .wb_wr_en     (bus.wb_wr_en),
      .wb_rd        (bus.wb_rd),
      .wb_data      (bus.wb_data),
      .data         (res1),
      .src          (src1),
      .ex_hit       (ex_hit1)
   );

   fwd_src_select #(.XLEN(XLEN), .REG_AW(REG_AW)) u_sel_rs2 (
      .rs           (bus.rs2),
      .use_rs       (bus.use_rs2),
      .rf_rdata     (bus.rf_rdata2),
      .ex_valid     (bus.ex_valid),
      .ex_wr_en     (bus.ex_wr_en),
      .ex_rd        (bus.ex_rd),
      .ex_fwd_data  (bus.ex_fwd_data),
      .mem_valid    (bus.mem_valid),
      .mem_wr_en    (bus.mem_wr_en),
      .mem_rd       (bus.mem_rd),
      .mem_fwd_data (bus.mem_fwd_data),
      .wb_valid     (bus.wb_valid),
      .wb_wr_en     (bus.wb_wr_en),
      .wb_rd        (bus.wb_rd),
      .wb_data      (bus.wb_data),
      .data         (res2),
      .src          (src2),
      .ex_hit       (ex_hit2)
   );

   // A load in EX feeding this instruction cannot forward yet
   always_comb begin
      load_use = bus.id_valid & (ex_hit1 | ex_hit2) & bus.ex_is_load;
   end

   // Next state, hold capture and stall/bubble decode. In LOAD_WAIT the
   // bubble sits in EX, so normal priority resolution picks up MEM data.
   // A freeze latches the operands so values retiring from WB meanwhile
   // cannot disturb what ID/EX finally consumes.
   always_comb begin
      state_d   = state_q;
      hold1_d   = hold1_q;
      hold2_d   = hold2_q;
      op1       = res1;
      op2       = res2;
      id_stall  = 1'b0;
      ex_bubble = 1'b0;
      case (state_q)
         ST_RUN: begin
            if (bus.id_valid && bus.stall_in) begin
               state_d  = ST_HOLD;
               hold1_d  = res1;
               hold2_d  = res2;
               id_stall = 1'b1;
            end else if (load_use) begin
               state_d   = ST_LOAD_WAIT;
               id_stall  = 1'b1;
               ex_bubble = 1'b1;
            end
         end
         ST_LOAD_WAIT: begin
            if (bus.mem_wait || bus.stall_in) begin
               id_stall  = 1'b1;
               ex_bubble = !bus.stall_in;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_HOLD: begin
            op1 = hold1_q;
            op2 = hold2_q;
            if (bus.stall_in) begin
               id_stall = 1'b1;
            end else begin
               state_d = ST_RUN;
            end
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase
      // Flush overrides everything, including a simultaneous freeze
      if (bus.flush) begin
         state_d   = ST_RUN;
         hold1_d   = hold1_q;
         hold2_d   = hold2_q;
         id_stall  = 1'b0;
         ex_bubble = 1'b0;
      end
   end

   // State and hold registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_RUN;
         hold1_q <= '0;
         hold2_q <= '0;
      end else begin
         state_q <= state_d;
         hold1_q <= hold1_d;
         hold2_q <= hold2_d;
      end
   end

   assign bus.op1       = op1;
   assign bus.op2       = op2;
   assign bus.id_stall  = id_stall;
   assign bus.ex_bubble = ex_bubble;
   assign state_dbg     = state_q;

`ifdef FWD_STATS_EN
   logic [STAT_W-1:0] stat_load_use_q, stat_load_use_d;
   logic [STAT_W-1:0] stat_wait_q, stat_wait_d;
   logic [STAT_W-1:0] stat_fwd_ex_q, stat_fwd_ex_d;
   logic [STAT_W-1:0] stat_fwd_mem_q, stat_fwd_mem_d;
   operand_src_t      hsrc1_q, hsrc1_d;
   operand_src_t      hsrc2_q, hsrc2_d;
   operand_src_t      eff1, eff2;
   logic              consume;
   logic [1:0]        n_ex, n_mem;

   // Event counting; a held operand is credited to the producer it was
   // captured from, at the cycle ID/EX actually takes it
   always_comb begin
      hsrc1_d = hsrc1_q;
      hsrc2_d = hsrc2_q;
      if (state_q == ST_RUN && state_d == ST_HOLD) begin
         hsrc1_d = src1;
         hsrc2_d = src2;
      end
      eff1    = (state_q == ST_HOLD) ? hsrc1_q : src1;
      eff2    = (state_q == ST_HOLD) ? hsrc2_q : src2;
      consume = bus.id_valid & ~id_stall & ~bus.flush;
      n_ex    = 2'd0;
      n_mem   = 2'd0;
      if (consume) begin
         n_ex  = {1'b0, eff1 == SRC_EX}  + {1'b0, eff2 == SRC_EX};
         n_mem = {1'b0, eff1 == SRC_MEM} + {1'b0, eff2 == SRC_MEM};
      end
      stat_load_use_d = stat_load_use_q;
      if (state_q == ST_RUN && state_d == ST_LOAD_WAIT) begin
         stat_load_use_d = sat_add(stat_load_use_q, 2'd1);
      end
      stat_wait_d = stat_wait_q;
      if (state_q == ST_LOAD_WAIT && bus.mem_wait) begin
         stat_wait_d = sat_add(stat_wait_q, 2'd1);
      end
      stat_fwd_ex_d  = sat_add(stat_fwd_ex_q, n_ex);
      stat_fwd_mem_d = sat_add(stat_fwd_mem_q, n_mem);
   end

   // Counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_load_use_q <= '0;
         stat_wait_q     <= '0;
         stat_fwd_ex_q   <= '0;
         stat_fwd_mem_q  <= '0;
         hsrc1_q         <= SRC_RF;
         hsrc2_q         <= SRC_RF;
      end else begin
         stat_load_use_q <= stat_load_use_d;
         stat_wait_q     <= stat_wait_d;
         stat_fwd_ex_q   <= stat_fwd_ex_d;
         stat_fwd_mem_q  <= stat_fwd_mem_d;
         hsrc1_q         <= hsrc1_d;
         hsrc2_q         <= hsrc2_d;
      end
   end

   assign bus.stat_load_use    = stat_load_use_q;
   assign bus.stat_wait_cycles = stat_wait_q;
   assign bus.stat_fwd_ex      = stat_fwd_ex_q;
   assign bus.stat_fwd_mem     = stat_fwd_mem_q;
`else
   // Source tags only feed the statistics block
   logic unused_src_tags;
   assign unused_src_tags = ^{src1, src2};
`endif

endmodule

// File: tb/tb_id_operand_resolver.sv
// Self-checking bench for id_operand_resolver. Expected operands come from
// a priority-search model over a producer table; pipeline-control
// expectations come from the load-use / freeze / flush rules directly.
// Counter checks are compiled in when FWD_STATS_EN is defined.
`timescale 1ns/1ps
module tb_id_operand_resolver;
   import id_operand_resolver_pkg::*;

   localparam int XLEN   = 32;
   localparam int REG_AW = 5;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   fsm_state_t state_dbg;

   int n_checks = 0;
   int n_err    = 0;
   int exp_load_use = 0;
   int exp_wait     = 0;

   logic [XLEN-1:0] exp_q[$];

   // Producer table, index 0=EX 1=MEM 2=WB (priority order)
   logic              p_v[3];
   logic              p_we[3];
   logic [REG_AW-1:0] p_rd[3];
   logic [XLEN-1:0]   p_data[3];

   id_operand_resolver_if #(.XLEN(XLEN), .REG_AW(REG_AW)) bus ();

   id_operand_resolver #(.XLEN(XLEN), .REG_AW(REG_AW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .state_dbg (state_dbg)
   );

   // Clock
   always #5 clk = ~clk;

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   function automatic logic [XLEN-1:0] ref_operand(input logic [REG_AW-1:0] rs,
                                                   input logic use_rs,
                                                   input logic [XLEN-1:0] rf);
      if (rs == '0) return '0;
      if (use_rs) begin
         for (int k = 0; k < 3; k++) begin
            if (p_v[k] && p_we[k] && p_rd[k] == rs) return p_data[k];
         end
      end
      return rf;
   endfunction

   // ---------------- checking ----------------
   task automatic chk(input string tag, input logic [XLEN-1:0] obs,
                      input logic [XLEN-1:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
      end
   endtask

   task automatic sb_check(input string tag, input logic [XLEN-1:0] obs);
      logic [XLEN-1:0] expv;
      if (exp_q.size() == 0) begin
         n_checks++;
         n_err++;
         $error("FAIL %s: scoreboard empty, observed=0x%0h", tag, obs);
      end else begin
         expv = exp_q.pop_front();
         chk(tag, obs, expv);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic apply_producers();
      bus.ex_valid     = p_v[0];
      bus.ex_wr_en     = p_we[0];
      bus.ex_rd        = p_rd[0];
      bus.ex_fwd_data  = p_data[0];
      bus.mem_valid    = p_v[1];
      bus.mem_wr_en    = p_we[1];
      bus.mem_rd       = p_rd[1];
      bus.mem_fwd_data = p_data[1];
      bus.wb_valid     = p_v[2];
      bus.wb_wr_en     = p_we[2];
      bus.wb_rd        = p_rd[2];
      bus.wb_data      = p_data[2];
   endtask

   task automatic set_prod(input int k, input logic v, input logic we,
                           input logic [REG_AW-1:0] rd, input logic [XLEN-1:0] d);
      p_v[k]    = v;
      p_we[k]   = we;
      p_rd[k]   = rd;
      p_data[k] = d;
      apply_producers();
   endtask

   task automatic set_id(input logic v, input logic [REG_AW-1:0] r1, input logic u1,
                         input logic [REG_AW-1:0] r2, input logic u2);
      bus.id_valid = v;
      bus.rs1      = r1;
      bus.use_rs1  = u1;
      bus.rs2      = r2;
      bus.use_rs2  = u2;
   endtask

   task automatic clear_all();
      for (int k = 0; k < 3; k++) begin
         p_v[k] = 1'b0; p_we[k] = 1'b0; p_rd[k] = '0; p_data[k] = '0;
      end
      apply_producers();
      set_id(1'b0, '0, 1'b0, '0, 1'b0);
      bus.flush      = 1'b0;
      bus.stall_in   = 1'b0;
      bus.ex_is_load = 1'b0;
      bus.mem_wait   = 1'b0;
      bus.rf_rdata1  = '0;
      bus.rf_rdata2  = '0;
   endtask

   // Inputs change on the falling edge; outputs are sampled 1ns later
   task automatic next_cycle();
      @(negedge clk);
   endtask

   // Detect cycle for an EX load feeding rs2 (the instruction stays in ID)
   task automatic start_load_use(input logic [REG_AW-1:0] rd);
      next_cycle();
      clear_all();
      set_id(1'b1, 5'd1, 1'b1, rd, 1'b1);
      bus.rf_rdata1 = 32'h0000_0101;
      bus.rf_rdata2 = 32'hDEAD_0000;
      set_prod(0, 1'b1, 1'b1, rd, $urandom());
      bus.ex_is_load = 1'b1;
      #1;
      chk("lu_detect_stall", 32'(bus.id_stall), 32'd1);
      chk("lu_detect_bubble", 32'(bus.ex_bubble), 32'd1);
      exp_load_use++;
   endtask

   // Load now in MEM with the bubble in EX
   task automatic load_in_mem(input logic [REG_AW-1:0] rd, input logic waiting,
                              input logic [XLEN-1:0] d);
      set_prod(0, 1'b0, 1'b0, '0, '0);
      bus.ex_is_load = 1'b0;
      bus.mem_wait   = waiting;
      set_prod(1, 1'b1, 1'b1, rd, d);
   endtask

   // Full load-use sequence with n_wait memory wait cycles
   task automatic load_use_seq(input int n_wait, input logic [REG_AW-1:0] rd,
                               input logic [XLEN-1:0] data);
      int stall_cnt;
      int bub_cnt;
      bit done;
      start_load_use(rd);
      stall_cnt = 1;
      bub_cnt   = 1;
      done      = 1'b0;
      for (int i = 0; i < 20 && !done; i++) begin
         next_cycle();
         load_in_mem(rd, 1'(i < n_wait), (i < n_wait) ? $urandom() : data);
         #1;
         if (bus.id_stall) begin
            stall_cnt++;
            bub_cnt += int'(bus.ex_bubble);
         end else begin
            done = 1'b1;
         end
      end
      exp_wait += n_wait;
      chk("lu_stall_cycles", 32'(stall_cnt), 32'(n_wait + 1));
      chk("lu_bubble_cycles", 32'(bub_cnt), 32'(n_wait + 1));
      chk("lu_op2", bus.op2, data);
      chk("lu_op1", bus.op1, 32'h0000_0101);
      // Load retires to WB; instruction has moved on
      next_cycle();
      clear_all();
      set_prod(2, 1'b1, 1'b1, rd, data);
      set_id(1'b1, rd, 1'b1, 5'd0, 1'b0);
      #1;
      chk("lu_after_state", 32'(state_dbg), 32'(ST_RUN));
      chk("lu_after_stall", 32'(bus.id_stall), 32'd0);
      chk("lu_after_op1", bus.op1, data);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [XLEN-1:0] d;
      logic [REG_AW-1:0] rd;

      clear_all();
      rst_n = 1'b0;
      repeat (2) next_cycle();
      #1;
      chk("rst_state", 32'(state_dbg), 32'(ST_RUN));
      chk("rst_stall", 32'(bus.id_stall), 32'd0);
      chk("rst_bubble", 32'(bus.ex_bubble), 32'd0);
      next_cycle();
      rst_n = 1'b1;
`ifdef FWD_STATS_EN
      #1;
      chk("rst_stat_load_use", bus.stat_load_use, 32'd0);
      chk("rst_stat_wait", bus.stat_wait_cycles, 32'd0);
      chk("rst_stat_fwd_ex", bus.stat_fwd_ex, 32'd0);
      chk("rst_stat_fwd_mem", bus.stat_fwd_mem, 32'd0);
`endif

      // Register-file path after reset
      next_cycle();
      set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1);
      bus.rf_rdata1 = 32'h0000_1234;
      bus.rf_rdata2 = 32'h0000_5678;
      #1;
      chk("rf_op1", bus.op1, 32'h0000_1234);
      chk("rf_op2", bus.op2, 32'h0000_5678);
      chk("rf_stall", 32'(bus.id_stall), 32'd0);

      // ALU dependency: EX beats MEM
      next_cycle();
      clear_all();
      set_prod(0, 1'b1, 1'b1, 5'd5, 32'h11);
      set_prod(1, 1'b1, 1'b1, 5'd5, 32'h22);
      set_id(1'b1, 5'd5, 1'b1, 5'd5, 1'b0);
      bus.rf_rdata2 = 32'h0000_0777;
      #1;
      chk("alu_op1", bus.op1, 32'h11);
      chk("alu_op2_unused_src", bus.op2, 32'h0000_0777);
      chk("alu_stall", 32'(bus.id_stall), 32'd0);

      // x0 never forwards
      next_cycle();
      clear_all();
      set_prod(0, 1'b1, 1'b1, 5'd0, 32'h55);
      set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b1);
      bus.rf_rdata1 = 32'hFFFF_FFFF;
      #1;
      chk("x0_op1", bus.op1, 32'h0);
      chk("x0_op2", bus.op2, 32'h0);

      // Randomized resolution in RUN (no load-use, no freeze)
      for (int i = 0; i < 150; i++) begin
         next_cycle();
         for (int k = 0; k < 3; k++) begin
            p_v[k]    = 1'($urandom_range(0, 1));
            p_we[k]   = 1'($urandom_range(0, 1));
            p_rd[k]   = 5'($urandom_range(0, 3));
            p_data[k] = $urandom();
         end
         apply_producers();
         set_id(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
         bus.rf_rdata1  = $urandom();
         bus.rf_rdata2  = $urandom();
         bus.ex_is_load = bus.id_valid ? 1'b0 : 1'($urandom_range(0, 1));
         bus.mem_wait   = 1'($urandom_range(0, 1));
         bus.flush      = ($urandom_range(0, 3) == 0);
         exp_q.push_back(ref_operand(bus.rs1, bus.use_rs1, bus.rf_rdata1));
         exp_q.push_back(ref_operand(bus.rs2, bus.use_rs2, bus.rf_rdata2));
         #1;
         sb_check("rnd_op1", bus.op1);
         sb_check("rnd_op2", bus.op2);
         chk("rnd_stall", 32'(bus.id_stall), 32'd0);
         chk("rnd_bubble", 32'(bus.ex_bubble), 32'd0);
      end

      // Load-use without memory wait, then with the plan's 3 wait cycles
      load_use_seq(0, 5'd7, 32'h0000_CAFE);
      load_use_seq(3, 5'd7, 32'h0000_BEEF);
      for (int i = 0; i < 3; i++) begin
         load_use_seq(int'($urandom_range(1, 5)), 5'($urandom_range(2, 31)), $urandom());
      end

      // Freeze: WB value changes while frozen, hold regs win through exit
      next_cycle();
      clear_all();
      set_prod(2, 1'b1, 1'b1, 5'd3, 32'hAB);
      set_id(1'b1, 5'd3, 1'b1, 5'd4, 1'b1);
      bus.rf_rdata2 = 32'h44;
      bus.stall_in  = 1'b1;
      #1;
      chk("frz0_op1", bus.op1, 32'hAB);
      chk("frz0_stall", 32'(bus.id_stall), 32'd1);
      chk("frz0_bubble", 32'(bus.ex_bubble), 32'd0);
      next_cycle();
      set_prod(2, 1'b1, 1'b1, 5'd3, 32'h99);
      bus.rf_rdata2 = 32'h55;
      #1;
      chk("frz1_state", 32'(state_dbg), 32'(ST_HOLD));
      chk("frz1_op1", bus.op1, 32'hAB);
      chk("frz1_op2", bus.op2, 32'h44);
      chk("frz1_stall", 32'(bus.id_stall), 32'd1);
      next_cycle();
      bus.stall_in = 1'b0;
      #1;
      chk("frz_exit_op1", bus.op1, 32'hAB);
      chk("frz_exit_op2", bus.op2, 32'h44);
      chk("frz_exit_stall", 32'(bus.id_stall), 32'd0);
      next_cycle();
      #1;
      chk("frz_after_state", 32'(state_dbg), 32'(ST_RUN));
      chk("frz_after_op1", bus.op1, 32'h99);
      chk("frz_after_op2", bus.op2, 32'h55);

      // Freeze has priority over load-use
      next_cycle();
      clear_all();
      set_prod(0, 1'b1, 1'b1, 5'd9, 32'h1);
      bus.ex_is_load = 1'b1;
      set_id(1'b1, 5'd9, 1'b1, 5'd0, 1'b0);
      bus.stall_in = 1'b1;
      #1;
      chk("prio_stall", 32'(bus.id_stall), 32'd1);
      chk("prio_bubble", 32'(bus.ex_bubble), 32'd0);
      next_cycle();
      clear_all();
      #1;
      chk("prio_state", 32'(state_dbg), 32'(ST_HOLD));
      chk("prio_exit_stall", 32'(bus.id_stall), 32'd0);

      // Freeze while waiting on a load: stall without bubble
      rd = 5'd12;
      d  = $urandom();
      start_load_use(rd);
      next_cycle();
      load_in_mem(rd, 1'b0, d);
      bus.stall_in = 1'b1;
      #1;
      chk("lwstall_stall", 32'(bus.id_stall), 32'd1);
      chk("lwstall_bubble", 32'(bus.ex_bubble), 32'd0);
      next_cycle();
      bus.stall_in = 1'b0;
      #1;
      chk("lwstall_exit_stall", 32'(bus.id_stall), 32'd0);
      chk("lwstall_exit_op2", bus.op2, d);

      // Flush in LOAD_WAIT
      start_load_use(5'd13);
      next_cycle();
      load_in_mem(5'd13, 1'b1, $urandom());
      bus.flush = 1'b1;
      exp_wait++;
      #1;
      chk("lwflush_stall", 32'(bus.id_stall), 32'd0);
      chk("lwflush_bubble", 32'(bus.ex_bubble), 32'd0);
      next_cycle();
      bus.flush = 1'b0;
      #1;
      chk("lwflush_state", 32'(state_dbg), 32'(ST_RUN));
      chk("lwflush_ignore_wait", 32'(bus.id_stall), 32'd0);

      // Flush with simultaneous freeze: no hold
      next_cycle();
      clear_all();
      set_prod(2, 1'b1, 1'b1, 5'd3, 32'h10);
      set_id(1'b1, 5'd3, 1'b1, 5'd0, 1'b0);
      bus.stall_in = 1'b1;
      bus.flush    = 1'b1;
      #1;
      chk("flstall_stall", 32'(bus.id_stall), 32'd0);
      next_cycle();
      bus.stall_in = 1'b0;
      bus.flush    = 1'b0;
      set_prod(2, 1'b1, 1'b1, 5'd3, 32'h20);
      #1;
      chk("flstall_state", 32'(state_dbg), 32'(ST_RUN));
      chk("flstall_op1", bus.op1, 32'h20);

      // No instruction in ID: a load hazard is not a stall
      next_cycle();
      clear_all();
      set_prod(0, 1'b1, 1'b1, 5'd6, 32'h6);
      bus.ex_is_load = 1'b1;
      set_id(1'b0, 5'd6, 1'b1, 5'd6, 1'b1);
      #1;
      chk("noid_stall", 32'(bus.id_stall), 32'd0);
      chk("noid_bubble", 32'(bus.ex_bubble), 32'd0);
      next_cycle();
      clear_all();
      #1;
      chk("noid_state", 32'(state_dbg), 32'(ST_RUN));

      // Reset in the middle of LOAD_WAIT
      start_load_use(5'd14);
      next_cycle();
      load_in_mem(5'd14, 1'b1, $urandom());
      exp_wait++;
      #1;
      chk("rstlw_stall_before", 32'(bus.id_stall), 32'd1);
`ifdef FWD_STATS_EN
      chk("stat_load_use", bus.stat_load_use, 32'(exp_load_use));
      chk("stat_wait", bus.stat_wait_cycles, 32'(exp_wait - 1));
`endif
      #1;
      rst_n = 1'b0;
      #1;
      chk("rstlw_state", 32'(state_dbg), 32'(ST_RUN));
      chk("rstlw_stall", 32'(bus.id_stall), 32'd0);
      chk("rstlw_bubble", 32'(bus.ex_bubble), 32'd0);
`ifdef FWD_STATS_EN
      chk("rstlw_stat_load_use", bus.stat_load_use, 32'd0);
      chk("rstlw_stat_wait", bus.stat_wait_cycles, 32'd0);
      chk("rstlw_stat_fwd_ex", bus.stat_fwd_ex, 32'd0);
      chk("rstlw_stat_fwd_mem", bus.stat_fwd_mem, 32'd0);
`endif
      next_cycle();
      rst_n = 1'b1;
      clear_all();
      next_cycle();
      #1;
      chk("post_rst_state", 32'(state_dbg), 32'(ST_RUN));

      // Final report
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
